// File: rtl/cd_multi.sv
// Multi-channel programmable clock divider with a valid/ready config port.
// Config writes take effect at the accept edge; c_ready drops for one COMMIT cycle after each accept.
module cd_multi #(
  parameter int NUM_CH            = 4,
  parameter int WIDTH_LIMIT       = 16,
  parameter int WIDTH_CONFIG_ADDR = 8,
  parameter int WIDTH_CONFIG_DATA = 16,
  parameter int DEFAULT_LIMIT     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
  input  logic                         c_valid,
  output logic                         c_ready,
  output logic                         c_err,
  output logic [NUM_CH-1:0]            clkout,
  output logic [NUM_CH-1:0]            tick
);

  localparam int WL = WIDTH_LIMIT;
  localparam int WA = WIDTH_CONFIG_ADDR;
  localparam logic [WA:0]   MAP_END = (WA+1)'(2 * NUM_CH);
  localparam logic [WL-1:0] DEF_LIM = WL'(DEFAULT_LIMIT);

  typedef enum logic {ST_IDLE, ST_COMMIT} state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;

  logic [NUM_CH-1:0][WL-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][WL-1:0] active_q, active_d;
  logic [NUM_CH-1:0][WL-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]         tgl_q, tgl_d;
  logic [NUM_CH-1:0]         en_q, en_d;
  logic [NUM_CH-1:0]         mode_q, mode_d;
  logic [NUM_CH-1:0]         mchg_q, mchg_d;
  logic [NUM_CH-1:0]         term;

  logic          accept;
  logic          mapped;
  logic          wr_map;
  logic [WA-2:0] wr_ch;
  logic          wr_ctrl;

  assign accept  = c_valid && (state_q == ST_IDLE);
  assign mapped  = {1'b0, c_addr} < MAP_END;
  assign wr_map  = accept && mapped;
  assign wr_ch   = c_addr[WA-1:1];
  assign wr_ctrl = c_addr[0];

  assign c_ready = (state_q == ST_IDLE);
  assign c_err   = err_q;

  always_comb begin
    state_d = state_q;
    err_d   = accept && !mapped;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    term   = '0;
    tick   = '0;
    clkout = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      term[k]   = en_q[k] && (cnt_q[k] == active_q[k]);
      tick[k]   = term[k];
      clkout[k] = en_q[k] && (mode_q[k] ? term[k] : tgl_q[k]);
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    tgl_d    = tgl_q;
    en_d     = en_q;
    mode_d   = mode_q;
    mchg_d   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_map && (wr_ch == (WA-1)'(k))) begin
        if (wr_ctrl) begin
          en_d[k]   = c_data[0];
          mode_d[k] = c_data[1];
          mchg_d[k] = c_data[1] ^ mode_q[k];
        end else begin
          shadow_d[k] = c_data[WL-1:0];
        end
      end
      // The active limit samples the pre-write shadow, so a write landing on a
      // terminal-count edge waits for the following terminal count.
      if (!en_q[k]) begin
        cnt_d[k]    = '0;
        tgl_d[k]    = 1'b0;
        active_d[k] = shadow_q[k];
      end else if (mchg_q[k]) begin
        cnt_d[k] = '0;
        tgl_d[k] = 1'b0;
      end else if (term[k]) begin
        cnt_d[k]    = '0;
        tgl_d[k]    = ~tgl_q[k];
        active_d[k] = shadow_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + WL'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= {NUM_CH{DEF_LIM}};
      shadow_q <= {NUM_CH{DEF_LIM}};
      tgl_q    <= '0;
      en_q     <= '1;
      mode_q   <= '0;
      mchg_q   <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      tgl_q    <= tgl_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      mchg_q   <= mchg_d;
    end
  end

endmodule

// File: tb/tb_cd_multi.sv
// Scoreboard bench for cd_multi: a segment-based timing model predicts every cycle's outputs.
module tb_cd_multi;

  localparam int NUM_CH = 4;
  localparam int WL     = 16;
  localparam int WA     = 8;
  localparam int WD     = 16;
  localparam int DEF    = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [WA-1:0]     c_addr;
  logic [WD-1:0]     c_data;
  logic              c_valid;
  logic              c_ready;
  logic              c_err;
  logic [NUM_CH-1:0] clkout;
  logic [NUM_CH-1:0] tick;

  always #5 clk = ~clk;

  cd_multi #(
    .NUM_CH(NUM_CH), .WIDTH_LIMIT(WL), .WIDTH_CONFIG_ADDR(WA),
    .WIDTH_CONFIG_DATA(WD), .DEFAULT_LIMIT(DEF)
  ) dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .c_ready(c_ready), .c_err(c_err), .clkout(clkout), .tick(tick)
  );

  typedef struct {
    logic              ready;
    logic              err;
    logic [NUM_CH-1:0] clko;
    logic [NUM_CH-1:0] tk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mdl_e;
  exp_t mon_e;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Each channel runs in segments: a segment starts at edge t0 with level lvl0
  // and a fixed limit, and outputs are pure arithmetic on cycles since t0.
  bit m_en[NUM_CH], m_mode[NUM_CH], m_mchg[NUM_CH], m_lvl0[NUM_CH];
  int m_shadow[NUM_CH], m_lim[NUM_CH], m_t0[NUM_CH];
  bit m_busy, m_err;
  bit m_term, m_lvl, m_nm;
  int m_ch;

  function automatic int pos_at(int k, int n);
    return (n - m_t0[k]) % (m_lim[k] + 1);
  endfunction

  function automatic bit tick_at(int k, int n);
    return m_en[k] && (pos_at(k, n) == m_lim[k]);
  endfunction

  function automatic bit lvl_at(int k, int n);
    return m_lvl0[k] ^ ((((n - m_t0[k]) / (m_lim[k] + 1)) % 2) == 1);
  endfunction

  function automatic bit clko_at(int k, int n);
    if (!m_en[k]) return 1'b0;
    return m_mode[k] ? tick_at(k, n) : lvl_at(k, n);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_en[k] = 1'b1; m_mode[k] = 1'b0; m_mchg[k] = 1'b0; m_lvl0[k] = 1'b0;
        m_shadow[k] = DEF; m_lim[k] = DEF; m_t0[k] = cyc;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_term = tick_at(k, cyc - 1);
        m_lvl  = lvl_at(k, cyc - 1);
        if (!m_en[k]) begin
          m_t0[k] = cyc; m_lvl0[k] = 1'b0; m_lim[k] = m_shadow[k];
        end else if (m_mchg[k]) begin
          m_t0[k] = cyc; m_lvl0[k] = 1'b0;
        end else if (m_term && (m_shadow[k] != m_lim[k])) begin
          m_t0[k] = cyc; m_lvl0[k] = !m_lvl; m_lim[k] = m_shadow[k];
        end
        m_mchg[k] = 1'b0;
      end
      if (!m_busy && c_valid) begin
        m_busy = 1'b1;
        m_err  = (c_addr >= 2 * NUM_CH);
        if (!m_err) begin
          m_ch = c_addr / 2;
          if (c_addr % 2 == 0) begin
            m_shadow[m_ch] = c_data;
          end else begin
            m_nm = c_data[1];
            m_mchg[m_ch] = (m_nm != m_mode[m_ch]);
            m_en[m_ch]   = c_data[0];
            m_mode[m_ch] = m_nm;
          end
        end
      end else begin
        m_busy = 1'b0;
        m_err  = 1'b0;
      end
    end
    mdl_e.ready = !m_busy;
    mdl_e.err   = m_err;
    for (int k = 0; k < NUM_CH; k++) begin
      mdl_e.clko[k] = clko_at(k, cyc);
      mdl_e.tk[k]   = tick_at(k, cyc);
    end
    exp_q.push_back(mdl_e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("c_ready", 32'(c_ready), 32'(mon_e.ready));
        chk("c_err",   32'(c_err),   32'(mon_e.err));
        chk("clkout",  32'(clkout),  32'(mon_e.clko));
        chk("tick",    32'(tick),    32'(mon_e.tk));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      c_valid = 1'b0;
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    c_valid = 1'b1;
    c_addr  = WA'(a);
    c_data  = WD'(d);
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  initial begin
    bit found;
    int a;
    rst = 1'b1; c_valid = 1'b0; c_addr = '0; c_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);

    idle(3);
    wr(2, 4);
    idle(40);

    wr(5, 3);
    wr(4, 2);
    idle(20);

    wr(2 * NUM_CH, 16'h00ff);
    idle(5);
    wr(200, 16'h0003);
    idle(5);

    wr(1, 0);
    idle(5);
    wr(0, 0);
    wr(1, 1);
    idle(12);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (tick_at(3, cyc)) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL ch3_terminal_wait: got no terminal count expected one within 100 cycles");
    end
    c_valid = 1'b1; c_addr = 8'd6; c_data = 16'd3;
    @(negedge clk);
    c_valid = 1'b0;
    idle(40);

    @(negedge clk); c_valid = 1'b1; c_addr = 8'd3; c_data = 16'd1;
    @(negedge clk); c_addr = 8'd3; c_data = 16'd0;
    @(negedge clk); c_addr = 8'd2; c_data = 16'd2;
    @(negedge clk); c_valid = 1'b0;
    idle(20);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      c_valid = ($urandom % 3 == 0);
      a = $urandom_range(0, 2 * NUM_CH + 1);
      c_addr = WA'(a);
      if (a % 2 == 0)
        c_data = WD'(($urandom % 8 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5));
      else
        c_data = WD'(($urandom % 4) | (($urandom % 4 != 0) ? 1 : 0));
    end
    idle(10);

    @(negedge clk); rst = 1'b1; c_valid = 1'b1; c_addr = 8'd2; c_data = 16'd7;
    @(negedge clk); rst = 1'b0; c_valid = 1'b0;
    idle(20);

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cd_multi.md
CD_MULTI -- requirements
Module: cd_multi

Interface
REQ-001 The block SHALL provide parameter NUM_CH, default 4, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL provide parameter WIDTH_LIMIT, default 16, giving the counter and limit width in bits.
REQ-003 The block SHALL provide parameter WIDTH_CONFIG_ADDR, default 8, giving the config address width.
REQ-004 The block SHALL provide parameter WIDTH_CONFIG_DATA, default 16 (>= WIDTH_LIMIT), giving the config data width.
REQ-005 The block SHALL provide parameter DEFAULT_LIMIT, default 1, giving the per-channel limit loaded at reset.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-008 The block SHALL have port c_addr, input, WIDTH_CONFIG_ADDR, the config register address.
REQ-009 The block SHALL have port c_data, input, WIDTH_CONFIG_DATA, the config write data.
REQ-010 The block SHALL have port c_valid, input, 1, the config write request.
REQ-011 The block SHALL have port c_ready, output, 1, meaning config write can be accepted.
REQ-012 The block SHALL have port c_err, output, 1, a one-cycle strobe flagging an unmapped address.
REQ-013 The block SHALL have port clkout, output, NUM_CH, the divided clock per channel.
REQ-014 The block SHALL have port tick, output, NUM_CH, a one-cycle strobe per channel at each terminal count.

Function
REQ-015 Address map: addr 2*k SHALL be LIMIT of channel k (low WIDTH_LIMIT bits of c_data); addr 2*k+1 SHALL be CTRL of channel k (bit0 EN, bit1 MODE: 0 = toggle, 1 = pulse); addresses >= 2*NUM_CH are unmapped.
REQ-016 A write SHALL be accepted on a rising edge where c_valid and c_ready are both 1; c_ready SHALL then be 0 for exactly the next cycle (COMMIT state) and return to 1 after it (IDLE state); c_valid while c_ready is 0 SHALL be ignored.
REQ-017 On acceptance of an unmapped address, no register SHALL change, and c_err SHALL be 1 for the single COMMIT cycle.
REQ-018 A LIMIT write SHALL update the channel's shadow limit at the accept edge; the active limit SHALL load from the shadow only on a terminal-count edge, or immediately on the next edge if the channel is disabled.
REQ-019 A CTRL write SHALL update EN and MODE at the accept edge; the counter SHALL act on the new values from the following cycle.
REQ-020 Each channel, when enabled, SHALL run a counter 0..active limit; at count == limit (terminal count) the counter SHALL wrap to 0 on the next edge and tick SHALL be 1 during that terminal cycle.
REQ-021 In toggle mode, clkout SHALL invert on each terminal-count edge, giving period 2*(limit+1) clk cycles at 50% duty; limit 0 SHALL give clk/2.
REQ-022 In pulse mode, clkout SHALL equal tick, giving period limit+1 cycles; limit 0 SHALL give clkout constantly 1.
REQ-023 Disabled channels SHALL hold counter = 0, clkout = 0, and tick = 0.
REQ-024 A shadow write coinciding with a terminal-count edge SHALL not be loaded on that edge; the active limit takes the prior shadow value, and the new value loads at the next terminal count.
REQ-025 A MODE change SHALL reset counter and clkout to 0 on the following edge.
REQ-026 Channels SHALL be fully independent; a write to channel k SHALL not perturb any other channel's counter or output.

Reset
REQ-027 With rst = 1 at a rising edge, all of the following SHALL hold at that edge:
- all counters = 0, clkout = 0, tick = 0, c_err = 0
- active and shadow limits = DEFAULT_LIMIT
- EN = 1, MODE = 0 for all channels
- state IDLE, c_ready = 1
REQ-028 A write in progress during reset SHALL be discarded.

Verification
REQ-029 Reset release, defaults -> every clkout toggles with period 4 clk, and c_ready = 1.
REQ-030 Write LIMIT ch1 = 4 mid-period -> the old period completes, then ch1 period = 10 clk; ch0, ch2, and ch3 are unchanged.
REQ-031 CTRL ch2 = 0x3 (pulse), LIMIT ch2 = 2 -> tick/clkout high 1 cycle in every 3; c_ready is low for 1 cycle after each accept.
REQ-032 Write to addr 2*NUM_CH -> c_err pulses once and no output changes.
REQ-033 CTRL ch0 = 0 -> clkout[0] = 0 from the next cycle; then LIMIT ch0 = 0 and CTRL ch0 = 1 -> clkout[0] = clk/2 immediately.
REQ-034 LIMIT write on the terminal-count edge of ch3 -> one more period at the old limit, then the new limit.
